lfsr_stream_ctrl: RTL
=====================

Name: lfsr_stream_ctrl

Overview:
Control and datapath stage directly downstream of the 80-bit LFSR keystream generator. It loads the LFSR seed and discards a fixed warm-up run of keystream bits. It then encrypts or decrypts DATA_W-bit words by XORing each word, LSB first, with successive Ser_out bits. Words enter and leave through valid/ready handshakes. It drives the LFSR's Par_load/shift_en/Seed and consumes its Ser_out.

Parameters:
SEED_W, 80, seed width; must match LFSR width
DATA_W, 8, data word width (1..32)
WARMUP, 160, keystream bits discarded after seed load (0 = no warm-up)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: latch seed_in, begin load + warm-up
seed_in  in  SEED_W  seed sampled when start accepted
lfsr_par_load  out  1  to LFSR Par_load
lfsr_shift_en  out  1  to LFSR shift_en
lfsr_seed  out  SEED_W  to LFSR Seed (registered copy of seed_in)
lfsr_ser_out  in  1  from LFSR Ser_out (current keystream bit)
din_valid  in  1  input word valid
din_ready  out  1  block can accept a word
din  in  DATA_W  plaintext/ciphertext word
dout_valid  out  1  result word valid
dout_ready  in  1  consumer accepts result
dout  out  DATA_W  din XOR keystream
busy  out  1  high in any state except IDLE

Behaviour:
- rst low (async): state=IDLE; all outputs 0: lfsr_par_load, lfsr_shift_en, lfsr_seed, din_ready, dout_valid, dout, busy; counters cleared. Reset mid-operation aborts immediately. Any partial word is lost.
- States: IDLE, LOAD, WARM, RUN, XOR, OUT.
- IDLE: start=1 latches seed_in into lfsr_seed. Next state LOAD. start in any other state is ignored.
- LOAD: exactly one cycle with lfsr_par_load=1, lfsr_shift_en=0. Next state is WARM, or RUN if WARMUP=0.
- WARM: lfsr_shift_en=1 for exactly WARMUP consecutive cycles. The warm-up counter counts 0..WARMUP-1. lfsr_ser_out is ignored. Next state RUN.
- RUN: din_ready=1, lfsr_shift_en=0. On din_valid&&din_ready, latch din into the shift buffer and clear the bit index. Next state XOR. The block stays in RUN indefinitely; the keystream does not advance while idle.
- XOR: exactly DATA_W cycles, lfsr_shift_en=1, din_ready=0.
  - In cycle i (i=0..DATA_W-1), result bit i = din[i] ^ lfsr_ser_out, sampled at that cycle's rising edge.
  - This is the same edge on which the LFSR shifts, so each keystream bit is used exactly once.
  - Next state OUT.
- OUT: dout_valid=1, dout stable, lfsr_shift_en=0, din_ready=0. On dout_ready=1, next state RUN and dout_valid clears on that edge. dout_ready low holds dout/dout_valid unchanged for any number of cycles.
- Latency: dout_valid rises DATA_W edges after the din accept edge. Peak throughput is one word per DATA_W+2 cycles.
- Key stream continuity: consecutive words use consecutive keystream bits with no gaps.
- Returning to IDLE requires reset. A new start is ignored once RUN is reached.
- busy=1 in LOAD, WARM, RUN, XOR, OUT.
- lfsr_par_load and lfsr_shift_en are never high together.

Optional Feature:
LFSR_STREAM_KS_CNT_EN
- Defined: adds output ks_cnt [31:0]. It counts every cycle with lfsr_shift_en=1, warm-up included. It wraps at 2^32. It resets to 0 on rst and on LOAD.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset and load: rst low then high; start=1 with seed_in=80'h1 -> lfsr_par_load=1 for one cycle. Then lfsr_shift_en=1 for exactly 160 cycles. Then din_ready=1; busy stays 1 throughout.
- Stubbed LFSR, WARMUP=0, lfsr_ser_out tied 1: din=8'h3C accepted -> dout=8'hC3 with dout_valid 8 edges after accept. Tied 0 -> dout=8'h3C.
- Alternating stub, lfsr_ser_out toggling 1,0,1,0 per shift cycle starting 1: din=8'h00 -> dout=8'h55. A second word 8'h00 -> 8'h55, confirming continuity with no lost bits.
- Backpressure: hold dout_ready=0 for 5 cycles in OUT -> dout/dout_valid stable, din_ready=0, lfsr_shift_en=0, no keystream advance.
- Integration with real LFSR, all-zero seed: din=8'hA5 -> dout=8'hA5. Any nonzero seed: dout matches a software model over 16 words. With LFSR_STREAM_KS_CNT_EN, ks_cnt=160+8*16=288.
- Reset mid-XOR (rst low at bit 3) -> immediate IDLE, all outputs 0. Start ignored while in RUN.

Source files
------------

// File: rtl/lfsr_stream_ctrl_if.sv
// Word handshake bundle for lfsr_stream_ctrl.
// The input side is din_valid/din_ready/din and the result side is dout_valid/dout_ready/dout.
interface lfsr_stream_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] din;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout;

    // The producer and consumer side, which is the testbench or the upstream logic.
    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout
    );

    // The controller side.
    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout
    );
endinterface

// File: rtl/lfsr_stream_ctrl.sv
// Seed load, warm-up discard and bit-serial XOR of words against the LFSR keystream.
// Optional: define LFSR_STREAM_KS_CNT_EN to add ks_cnt, a running count of keystream shifts.
module lfsr_stream_ctrl #(
    parameter int unsigned SEED_W = 80,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WARMUP = 160
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed_in,
    output logic              lfsr_par_load,
    output logic              lfsr_shift_en,
    output logic [SEED_W-1:0] lfsr_seed,
    input  logic              lfsr_ser_out,
    lfsr_stream_ctrl_if.slave bus,
`ifdef LFSR_STREAM_KS_CNT_EN
    output logic [31:0]       ks_cnt,
`endif
    output logic              busy
);
    localparam int unsigned CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WARM = 3'd2,
        RUN  = 3'd3,
        XOR  = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  warm_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_buf;
    logic [DATA_W-1:0] buf_rot;
    logic [DATA_W-1:0] dout_q;
    logic              din_ready_q;
    logic              dout_valid_q;
    logic              accept;
    logic              xor_last;

    assign bus.din_ready  = din_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;

    // Rotate right, placing the encrypted LSB at the top. After DATA_W steps each bit is back in place.
    assign buf_rot = (shift_buf >> 1) |
                     (DATA_W'(shift_buf[0] ^ lfsr_ser_out) << (DATA_W - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and the handshake strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        xor_last  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = (WARMUP == 0) ? RUN : WARM;
            WARM: if (warm_cnt == CNT_W'(WARMUP - 1)) state_nxt = RUN;
            RUN: begin
                if (bus.din_valid) begin
                    accept    = 1'b1;
                    state_nxt = XOR;
                end
            end
            XOR: begin
                if (bit_idx == IDX_W'(DATA_W - 1)) begin
                    xor_last  = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: if (bus.dout_ready) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs are registered from next state, so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_par_load <= 1'b0;
            lfsr_shift_en <= 1'b0;
            din_ready_q   <= 1'b0;
            dout_valid_q  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            lfsr_par_load <= (state_nxt == LOAD);
            lfsr_shift_en <= (state_nxt == WARM) || (state_nxt == XOR);
            din_ready_q   <= (state_nxt == RUN);
            dout_valid_q  <= (state_nxt == OUT);
            busy          <= (state_nxt != IDLE);
        end
    end

    // Seed capture, warm-up counter, bit index, shift buffer and result word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_seed <= '0;
            warm_cnt  <= '0;
            bit_idx   <= '0;
            shift_buf <= '0;
            dout_q    <= '0;
        end else begin
            if (state == IDLE && start) lfsr_seed <= seed_in;
            if (state == WARM) warm_cnt <= warm_cnt + CNT_W'(1);
            else               warm_cnt <= '0;
            if (accept) begin
                bit_idx   <= '0;
                shift_buf <= bus.din;
            end else if (state == XOR) begin
                bit_idx   <= bit_idx + IDX_W'(1);
                shift_buf <= buf_rot;
            end
            if (xor_last) dout_q <= buf_rot;
        end
    end

`ifdef LFSR_STREAM_KS_CNT_EN
    // Count every keystream shift since the last seed load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                ks_cnt <= '0;
        else if (state == LOAD)  ks_cnt <= '0;
        else if (lfsr_shift_en)  ks_cnt <= ks_cnt + 32'd1;
    end
`endif
endmodule
